// File: rtl/store_merge_unit_pkg.sv
// ============================================================================
// Module      : mips_mem_defs (package)
// Description : Shared store-path definitions: size codes, store FSM state
//               encoding, alignment rule and byte-lane merge helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_mem_defs;

  // Store width codes carried on req_size
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Store sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // A request is rejected when the width code is reserved or the address
  // is not a multiple of the access width.
  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = offset[0];
      SZ_W:    bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Insert the low byte/half of data into the little-endian lane of word
  // selected by offset. Bits of data above the store width are dropped.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  offset);
    logic [31:0] res;
    res = word;
    case (size)
      SZ_B:    res[{offset, 3'b000} +: 8]     = data[7:0];
      SZ_H:    res[{offset[1], 4'b0000} +: 16] = data[15:0];
      SZ_W:    res = data;
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_merge_unit_lane_merge.sv
// ============================================================================
// Module      : lane_merge
// Description : Combinational byte-lane insertion of a narrow store value
//               into a 32-bit RAM word (little-endian lanes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_merge
  import mips_mem_defs::*;
(
  input  logic [31:0] word,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  // Pure lane substitution; kept as its own block so SWL/SWR can reuse it
  always_comb begin
    merged = merge_lane(word, data, size, offset);
  end

endmodule

`default_nettype wire

// File: rtl/store_merge_unit.sv
// ============================================================================
// Module      : store_merge_unit
// Description : Store-path narrowing unit. Accepts SB/SH/SW requests, checks
//               alignment, and writes a word-only synchronous RAM, using a
//               read-modify-write sequence for byte and halfword stores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_merge_unit
  import mips_mem_defs::*;
#(
  parameter int AW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_size,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_data,
  output logic          done,
  output logic          err,
  output logic [AW-3:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  // Last value of the read-latency counter; WAIT lasts RD_LAT cycles
  localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

  state_t        state;
  state_t        state_nx;

  logic [1:0]    size_q;
  logic [1:0]    off_q;
  logic [31:0]   data_q;
  logic [AW-3:0] idx_q;
  logic [31:0]   merge_q;
  logic [1:0]    cnt_q;

  logic          accept;
  logic          req_bad;
  logic          cnt_last;
  logic [31:0]   merged;

  assign accept   = req_valid && req_ready;
  assign req_bad  = is_bad(req_size, req_addr[1:0]);
  assign cnt_last = (cnt_q == CNT_LAST);
  assign mem_addr = idx_q;

  // Insert the latched store value into the word returned by the RAM
  lane_merge u_lane_merge (
    .word   (mem_rdata),
    .data   (data_q),
    .size   (size_q),
    .offset (off_q),
    .merged (merged)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Request latch, read-latency counter and merge register
  always_ff @(posedge clk) begin
    if (rst) begin
      size_q  <= SZ_B;
      off_q   <= 2'b00;
      data_q  <= 32'h0;
      idx_q   <= '0;
      merge_q <= 32'h0;
      cnt_q   <= 2'b00;
    end else begin
      if (accept) begin
        size_q <= req_size;
        off_q  <= req_addr[1:0];
        data_q <= req_data;
        idx_q  <= req_addr[AW-1:2];
        // A full-word store needs no read: the merge word is the data itself
        if (req_size == SZ_W) begin
          merge_q <= req_data;
        end
      end

      if (state == ST_RD) begin
        cnt_q <= 2'b00;
      end else if ((state == ST_WAIT) && !cnt_last) begin
        cnt_q <= cnt_q + 2'd1;
      end

      // Read data is valid in the final WAIT cycle; capture it already merged
      if ((state == ST_WAIT) && cnt_last) begin
        merge_q <= merged;
      end
    end
  end

  // Next-state logic and Moore outputs
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 32'h0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad) begin
            state_nx = ST_ERR;
          end else if (req_size == SZ_W) begin
            state_nx = ST_WR;
          end else begin
            state_nx = ST_RD;
          end
        end
      end
      ST_RD: begin
        mem_re   = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_last) begin
          state_nx = ST_WR;
        end
      end
      ST_WR: begin
        mem_we    = 1'b1;
        mem_wdata = merge_q;
        done      = 1'b1;
        state_nx  = ST_IDLE;
      end
      ST_ERR: begin
        err      = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_store_merge_unit.sv
// ============================================================================
// Module      : tb_store_merge_unit
// Description : Bench for store_merge_unit with RD_LAT=1 and RD_LAT=2 copies,
//               a byte-addressed reference memory and a pulse scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_store_merge_unit;
  import mips_mem_defs::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_err;
    int          idx;
    logic [31:0] wdata;
    int          acc;
    int          lat;
    int          nre;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_lat
    localparam int LAT = gi + 1;

    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        done;
    logic        err;
    logic [29:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:63];
    logic [31:0] pre_img [0:63];
    logic        pre_en;
    logic [31:0] p1, p2;
    logic [7:0]  ref_b [0:255];
    exp_t        q[$];
    int          re_cnt = 0;
    bit          expect_ready = 0;
    bit          fin = 0;

    store_merge_unit #(.AW(32), .RD_LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_size  (req_size),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .done      (done),
      .err       (err),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
    );

    // Synchronous RAM: read data is garbage except LAT cycles after a read
    always @(posedge clk) begin
      if (mem_re) p1 <= ram[mem_addr[5:0]];
      else        p1 <= $urandom;
      p2 <= p1;
      if (pre_en) begin
        for (int i = 0; i < 64; i++) ram[i] <= pre_img[i];
      end else if (mem_we) begin
        ram[mem_addr[5:0]] <= mem_wdata;
      end
    end
    assign mem_rdata = (LAT == 1) ? p1 : p2;

    function automatic logic [31:0] ref_word(input int w);
      return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    // Monitor: every done/err pulse retires one scoreboard entry
    always @(negedge clk) begin
      exp_t e;
      if (rst) begin
        re_cnt = 0;
        expect_ready = 0;
      end else begin
        if (expect_ready) begin
          check($sformatf("L%0d ready_after_pulse", LAT), 32'(req_ready), 32'd1);
          expect_ready = 0;
        end
        if (mem_re) begin
          re_cnt++;
          check($sformatf("L%0d we_with_re", LAT), 32'(mem_we), 32'd0);
        end
        if (mem_we || done || err) begin
          if (q.size() == 0) begin
            check($sformatf("L%0d unexpected_pulse", LAT), 32'({mem_we, done, err}), 32'd0);
          end else begin
            e = q.pop_front();
            if (e.is_err) begin
              check($sformatf("L%0d err_pulse", LAT), 32'({mem_we, done, err}), 32'b001);
            end else begin
              check($sformatf("L%0d done_we", LAT), 32'({mem_we, done, err}), 32'b110);
              check($sformatf("L%0d mem_addr", LAT), 32'(mem_addr), 32'(e.idx));
              check($sformatf("L%0d mem_wdata", LAT), mem_wdata, e.wdata);
            end
            check($sformatf("L%0d latency", LAT), 32'(cyc - e.acc + 1), 32'(e.lat));
            check($sformatf("L%0d read_count", LAT), 32'(re_cnt), 32'(e.nre));
            re_cnt = 0;
            expect_ready = 1;
          end
        end
      end
    end

    // Offer one request at the next idle negedge; junk is driven while busy
    task automatic issue(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      int   nb;
      int   w;
      w = 0;
      while (!req_ready) begin
        req_valid = 1'($urandom_range(0, 1));
        req_size  = 2'($urandom);
        req_addr  = $urandom;
        req_data  = $urandom;
        @(negedge clk);
        w++;
        if (w > 20) begin
          check($sformatf("L%0d ready_timeout", LAT), 32'(req_ready), 32'd1);
          return;
        end
      end
      req_valid = 1'b1;
      req_size  = s;
      req_addr  = a;
      req_data  = d;
      nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
      e.acc    = cyc + 1;
      e.is_err = (nb == 0) || ((a % nb) != 0);
      e.idx    = int'(a >> 2);
      if (e.is_err) begin
        e.lat   = 1;
        e.nre   = 0;
        e.wdata = 32'h0;
      end else begin
        for (int k = 0; k < nb; k++) ref_b[int'(a) + k] = d[8*k +: 8];
        e.wdata = ref_word(e.idx);
        e.lat   = (nb == 4) ? 1 : LAT + 2;
        e.nre   = (nb == 4) ? 0 : 1;
      end
      q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
    endtask

    initial begin
      int w;
      logic [1:0]  s;
      logic [31:0] a;
      int          nb;
      rst = 1'b1; req_valid = 1'b0; req_size = 2'b00; req_addr = 32'h0; req_data = 32'h0;
      for (int i = 0; i < 64; i++) begin
        pre_img[i] = (i == 4) ? 32'h1122_3344 : $urandom;
        for (int k = 0; k < 4; k++) ref_b[4*i+k] = pre_img[i][8*k +: 8];
      end
      pre_en = 1'b1;
      repeat (3) @(negedge clk);
      pre_en = 1'b0;
      check($sformatf("L%0d rst_ready", LAT), 32'(req_ready), 32'd1);
      check($sformatf("L%0d rst_pulses", LAT), 32'({done, err, mem_re, mem_we}), 32'd0);
      check($sformatf("L%0d rst_mem_addr", LAT), 32'(mem_addr), 32'd0);
      check($sformatf("L%0d rst_wdata", LAT), mem_wdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases around RAM word 4 = 0x1122_3344
      issue(SZ_W, 32'h10, 32'hDEAD_BEEF);
      issue(SZ_W, 32'h10, 32'h1122_3344);
      issue(SZ_B, 32'h12, 32'hFFFF_FFAB);
      issue(SZ_W, 32'h10, 32'h1122_3344);
      issue(SZ_H, 32'h12, 32'h0000_CAFE);
      issue(SZ_W, 32'h10, 32'h1122_3344);
      issue(SZ_H, 32'h10, 32'h0000_CAFE);
      issue(SZ_H, 32'h13, 32'h0000_1234);
      issue(SZ_W, 32'h12, 32'h5555_AAAA);
      issue(2'b11, 32'h14, 32'h0BAD_F00D);

      // Reset while an SB waits for read data: no write, no done
      w = 0;
      while (!req_ready && w < 20) begin @(negedge clk); w++; end
      req_valid = 1'b1; req_size = SZ_B; req_addr = 32'h21; req_data = 32'h0000_0077;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check($sformatf("L%0d rst_wait_ready", LAT), 32'(req_ready), 32'd1);
      check($sformatf("L%0d rst_wait_pulses", LAT), 32'({mem_we, done, err}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(SZ_W, 32'h20, 32'hA5A5_0F0F);

      // Randomised traffic, back-to-back with occasional gaps
      for (int n = 0; n < 120; n++) begin
        w = $urandom_range(0, 9);
        s = (w < 3) ? SZ_B : (w < 6) ? SZ_H : (w < 9) ? SZ_W : 2'b11;
        nb = (s == SZ_B) ? 1 : (s == SZ_H) ? 2 : 4;
        a = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 9) < 7) a = a & ~(32'(nb) - 32'd1);
        issue(s, a, $urandom);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      end

      w = 0;
      while (q.size() != 0 && w < 50) begin @(negedge clk); w++; end
      check($sformatf("L%0d drain", LAT), 32'(q.size()), 32'd0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 64; i++)
        check($sformatf("L%0d ram_word[%0d]", LAT, i), ram[i], ref_word(i));
      fin = 1;
    end
  end

  initial begin
    wait (g_lat[0].fin && g_lat[1].fin);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/store_merge_unit.md
# store_merge_unit

Store-path narrowing unit for the MIPS data memory: the write-side counterpart of the load/immediate extension logic. It takes a 32-bit register value plus a store width (SB/SH/SW), drops the unused upper bits, and writes only the selected byte lanes of a word-only synchronous RAM. Narrow stores use a read-modify-write sequence. The unit sits between the MEM stage and the data RAM, and stalls the pipeline via a ready/valid handshake.

## Interface
Parameters:
- AW, 32, byte address width; the RAM word index is addr[AW-1:2]
- RD_LAT, 1, RAM read latency in cycles; 1 and 2 are supported

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  reset, synchronous and active-high
- req_valid  in  1  store request present
- req_ready  out  1  unit idle and able to accept a request
- req_size  in  2  store width: 2'b00 SB, 2'b01 SH, 2'b10 SW; 2'b11 is illegal
- req_addr  in  AW  byte address
- req_data  in  32  register value; only the low byte/half/word is used
- done  out  1  one-cycle pulse when a store has completed
- err  out  1  one-cycle pulse when a request is misaligned or illegal
- mem_addr  out  AW-2  word index
- mem_re  out  1  RAM read strobe
- mem_we  out  1  RAM write strobe (full word)
- mem_wdata  out  32  word written to RAM
- mem_rdata  in  32  RAM read data, valid RD_LAT cycles after mem_re

## Operation
- Byte order is little-endian:
  - byte lane = addr[1:0], so lane k is bits [8k+7:8k]
  - halfword lane = addr[1], so the half occupies bits [16·addr[1]+15 : 16·addr[1]]
- A request is accepted when req_valid && req_ready. On acceptance, req_size, req_addr and req_data are latched.
- Alignment check:
  - SH with addr[0]=1 is misaligned
  - SW with addr[1:0]≠0 is misaligned
  - size 2'b11 is illegal
  - A misaligned or illegal request goes to ERR: no RAM access occurs, err pulses, and done does not pulse.
- FSM states: IDLE, RD, WAIT, WR, ERR.
  - IDLE: req_ready=1.
    - Accepted SW → WR.
    - Accepted SB/SH → RD.
    - Bad request → ERR.
  - RD: mem_re=1 for one cycle, mem_addr = latched word index. Next state is WAIT.
  - WAIT: counts RD_LAT-1 further cycles, then samples mem_rdata into the merge register. Next state is WR.
  - WR: mem_we=1 for one cycle. Next state is IDLE, with done pulsing in that cycle.
    - For SW, mem_wdata = req_data.
    - For SB/SH, mem_wdata = the sampled word with only the selected lane(s) replaced by req_data[7:0] or req_data[15:0].
  - ERR: err=1 for one cycle. Next state is IDLE.
- Upper bits of req_data above the store width never reach the RAM.
- mem_re and mem_we are never asserted in the same cycle.

## Timing
- Reset: state=IDLE, req_ready=1, done=0, err=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, merge register=0.
- Latency from the acceptance edge to the done pulse:
  - SW: 1 cycle (WR)
  - SB/SH: RD_LAT+2 cycles (RD, WAIT, WR); 3 cycles when RD_LAT=1
  - Error: err pulses 1 cycle after acceptance.
- req_ready is deasserted from the cycle after acceptance until the state returns to IDLE. Back-to-back requests are accepted in the cycle after done or err.
- Input changes while busy are ignored, because all request fields are latched.
- Reset mid-sequence: state returns to IDLE on the next edge.
  - An in-flight read is discarded.
  - No write is issued unless the WR cycle itself had already occurred.
  - done/err do not pulse.
- mem_addr holds the latched word index from RD through WR.

## Structure
- Shared package/header `mips_mem_defs`:
  - size codes SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10
  - FSM state encodings
  - lane-merge function merge_lane(word, data, size, offset)
- One natural sub-module, `lane_merge`: combinational byte-lane insertion, reused later by an SWL/SWR extension.
- The FSM and latency counter live in the top module.

## Test plan
- SW: addr=0x0000_0010, data=0xDEAD_BEEF → WR one cycle after acceptance, mem_addr=0x4, mem_wdata=0xDEADBEEF, done pulses, mem_re never asserted.
- SB: RAM word at index 4 = 0x1122_3344, addr=0x12, data=0xFFFF_FFAB → read then write 0x11AB_3344, done 3 cycles after acceptance (RD_LAT=1).
- SH: same RAM word, addr=0x12, data=0x0000_CAFE → write 0xCAFE_3344. Repeat with addr=0x10 → write 0x1122_CAFE.
- Misaligned SH at addr=0x13 and SW at addr=0x12 → err pulses 1 cycle after acceptance, mem_we and mem_re stay 0, req_ready returns to 1.
- rst asserted in WAIT during an SB → next cycle state is IDLE, no mem_we, no done. A following SW completes normally.
- RD_LAT=2 build, SB: read data arrives 2 cycles after mem_re, merge is correct, done 4 cycles after acceptance. Back-to-back SB then SW are accepted without gaps beyond the rules above.
